// File: rtl/types.sv
// types: shared state and bus-owner encodings for the data-bus arbiter
package types;
    typedef enum logic {IDLE = 1'b0, HOST_WAIT = 1'b1} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_HOST = 2'd2} owner_t;
endpackage

// File: rtl/if_dbus.sv
// if_dbus: word-addressed data bus with a one-cycle registered read return
interface if_dbus;
    logic [15:0] adr;
    logic [15:0] dat_o;
    logic [15:0] dat_i;
    logic        re;
    logic        we;
    modport master (output adr, re, we, dat_o, input dat_i);
    modport slave (input adr, re, we, dat_o, output dat_i);
endinterface

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the data RAM between the core (absolute priority) and a host port
module dbus_arbiter
    import types::*;
#(
    parameter logic [15:0] PROT_BASE = 16'h7000
) (
    input  logic        clk,
    input  logic        reset,
    if_dbus.slave       cpu,
    if_dbus.master      mem,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [15:0] host_adr,
    input  logic [15:0] host_dat_o,
    output logic        host_ack,
    output logic [15:0] host_dat_i,
    output logic        host_err
);
    arb_state_t state;
    owner_t     owner;
    logic       err_q;
    logic       cpu_act;
    logic       grant;
    logic       prot;
    always_comb begin
        cpu_act    = ~reset & (cpu.re | cpu.we);
        grant      = ~reset & (state == IDLE) & host_req & ~cpu_act;
        prot       = host_we & (host_adr >= PROT_BASE);
        mem.adr    = cpu_act ? cpu.adr : grant ? host_adr : 16'h0;
        mem.dat_o  = cpu_act ? cpu.dat_o : grant ? host_dat_o : 16'h0;
        mem.re     = cpu_act ? cpu.re : grant & ~host_we;
        mem.we     = cpu_act ? cpu.we : grant & host_we & ~prot;
        host_ack   = ~reset & (state == HOST_WAIT);
        host_err   = host_ack & err_q;
        host_dat_i = host_ack ? mem.dat_i : 16'h0;
        cpu.dat_i  = (owner == OWN_CPU) ? mem.dat_i : 16'h0;
    end
    // owner remembers who drove the RAM last cycle, so read data is routed only to it
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= OWN_NONE;
            err_q <= 1'b0;
        end else begin
            state <= grant ? HOST_WAIT : IDLE;
            owner <= cpu_act ? OWN_CPU : grant ? OWN_HOST : OWN_NONE;
            err_q <= grant & prot;
        end
    end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed vectors against a registered-read RAM model
module tb_dbus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        host_req;
    logic        host_we;
    logic [15:0] host_adr;
    logic [15:0] host_dat_o;
    logic        host_ack;
    logic [15:0] host_dat_i;
    logic        host_err;
    logic [15:0] ram [0:255];
    logic        bad_we = 1'b0;
    int          n_run = 0;
    int          n_fail = 0;
    if_dbus cpu_bus ();
    if_dbus mem_bus ();
    dbus_arbiter #(.PROT_BASE(16'h7000)) dut (
        .clk(clk), .reset(reset), .cpu(cpu_bus.slave), .mem(mem_bus.master),
        .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_dat_o(host_dat_o),
        .host_ack(host_ack), .host_dat_i(host_dat_i), .host_err(host_err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (mem_bus.we) ram[mem_bus.adr[7:0]] <= mem_bus.dat_o;
        if (mem_bus.re) mem_bus.dat_i <= ram[mem_bus.adr[7:0]];
        if (!reset && mem_bus.we && mem_bus.adr >= 16'h7000) bad_we <= 1'b1;
    end
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0;
        ram[8'h10] = 16'hBEEF;
        ram[8'h20] = 16'h1111;
        ram[8'h30] = 16'h3030;
        ram[8'h31] = 16'h3131;
        ram[8'h00] = 16'hAAAA;
        ram[8'hFF] = 16'h5555;
        mem_bus.dat_i = 16'h0;
        reset = 1'b1;
        host_req = 1'b0; host_we = 1'b0; host_adr = 16'h0; host_dat_o = 16'h0;
        cpu_bus.re = 1'b1; cpu_bus.we = 1'b0; cpu_bus.adr = 16'h0010; cpu_bus.dat_o = 16'h0;
        step; step;
        chk("rst_mem_re", {15'd0, mem_bus.re}, 16'd0);
        chk("rst_mem_we", {15'd0, mem_bus.we}, 16'd0);
        chk("rst_ack", {15'd0, host_ack}, 16'd0);
        chk("rst_err", {15'd0, host_err}, 16'd0);
        chk("rst_hdat", host_dat_i, 16'h0);
        chk("rst_cdat", cpu_bus.dat_i, 16'h0);
        cpu_bus.re = 1'b0;
        reset = 1'b0;
        step;
        // core read
        cpu_bus.re = 1'b1; cpu_bus.adr = 16'h0010;
        #1;
        chk("cr_mem_re", {15'd0, mem_bus.re}, 16'd1);
        chk("cr_mem_adr", mem_bus.adr, 16'h0010);
        step;
        cpu_bus.re = 1'b0; cpu_bus.adr = 16'h0;
        #1;
        chk("cr_cdat", cpu_bus.dat_i, 16'hBEEF);
        chk("cr_ack", {15'd0, host_ack}, 16'd0);
        chk("idle_adr", mem_bus.adr, 16'h0);
        chk("idle_re", {15'd0, mem_bus.re}, 16'd0);
        step;
        // collision: core write wins, host read follows
        host_req = 1'b1; host_we = 1'b0; host_adr = 16'h0020;
        cpu_bus.we = 1'b1; cpu_bus.adr = 16'h0040; cpu_bus.dat_o = 16'h4444;
        #1;
        chk("col_mem_we", {15'd0, mem_bus.we}, 16'd1);
        chk("col_mem_adr", mem_bus.adr, 16'h0040);
        chk("col_mem_dat", mem_bus.dat_o, 16'h4444);
        step;
        cpu_bus.we = 1'b0; cpu_bus.adr = 16'h0; cpu_bus.dat_o = 16'h0;
        #1;
        chk("col_grant_re", {15'd0, mem_bus.re}, 16'd1);
        chk("col_grant_adr", mem_bus.adr, 16'h0020);
        chk("col_ack0", {15'd0, host_ack}, 16'd0);
        step;
        chk("col_ack", {15'd0, host_ack}, 16'd1);
        chk("col_hdat", host_dat_i, 16'h1111);
        chk("col_err", {15'd0, host_err}, 16'd0);
        host_req = 1'b0;
        step;
        chk("col_ram", ram[8'h40], 16'h4444);
        chk("col_ack_end", {15'd0, host_ack}, 16'd0);
        // protected write rejected
        host_req = 1'b1; host_we = 1'b1; host_adr = 16'h7000; host_dat_o = 16'h1234;
        #1;
        chk("prot_we", {15'd0, mem_bus.we}, 16'd0);
        chk("prot_re", {15'd0, mem_bus.re}, 16'd0);
        step;
        chk("prot_ack", {15'd0, host_ack}, 16'd1);
        chk("prot_err", {15'd0, host_err}, 16'd1);
        host_req = 1'b0;
        step;
        chk("prot_ram", ram[8'h00], 16'hAAAA);
        chk("prot_err_end", {15'd0, host_err}, 16'd0);
        // just below the protected window
        host_req = 1'b1; host_we = 1'b1; host_adr = 16'h6FFF; host_dat_o = 16'h1234;
        #1;
        chk("low_we", {15'd0, mem_bus.we}, 16'd1);
        step;
        chk("low_ack", {15'd0, host_ack}, 16'd1);
        chk("low_err", {15'd0, host_err}, 16'd0);
        host_req = 1'b0; host_we = 1'b0;
        step;
        chk("low_ram", ram[8'hFF], 16'h1234);
        // interleave: core reads every other cycle, host held
        host_req = 1'b1; host_we = 1'b0; host_adr = 16'h0030;
        for (int i = 0; i <= 6; i++) begin
            cpu_bus.re = (i % 2 == 0); cpu_bus.adr = (i % 2 == 0) ? 16'h0010 : 16'h0;
            #1;
            if (i % 2 == 1) begin
                chk("il_ack_odd", {15'd0, host_ack}, 16'd0);
                chk("il_cdat_odd", cpu_bus.dat_i, 16'hBEEF);
                chk("il_grant", mem_bus.adr, 16'h0030);
            end else if (i >= 2) begin
                chk("il_ack_even", {15'd0, host_ack}, 16'd1);
                chk("il_hdat", host_dat_i, 16'h3030);
                chk("il_cdat_even", cpu_bus.dat_i, 16'h0);
            end
            step;
        end
        cpu_bus.re = 1'b0; cpu_bus.adr = 16'h0; host_req = 1'b0;
        step;
        // reset during HOST_WAIT aborts the access
        host_req = 1'b1; host_adr = 16'h0031;
        step;
        host_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("ab_ack", {15'd0, host_ack}, 16'd0);
        chk("ab_hdat", host_dat_i, 16'h0);
        step;
        reset = 1'b0;
        #1;
        chk("ab_ack_after", {15'd0, host_ack}, 16'd0);
        // back-to-back host reads, first one right after reset
        host_req = 1'b1; host_we = 1'b0; host_adr = 16'h0030;
        #1;
        chk("bb_g0_re", {15'd0, mem_bus.re}, 16'd1);
        chk("bb_g0_adr", mem_bus.adr, 16'h0030);
        step;
        chk("bb_ack1", {15'd0, host_ack}, 16'd1);
        chk("bb_dat1", host_dat_i, 16'h3030);
        host_adr = 16'h0031;
        #1;
        chk("bb_nogrant", {15'd0, mem_bus.re}, 16'd0);
        step;
        chk("bb_g2_re", {15'd0, mem_bus.re}, 16'd1);
        chk("bb_g2_adr", mem_bus.adr, 16'h0031);
        chk("bb_ack2", {15'd0, host_ack}, 16'd0);
        step;
        chk("bb_ack3", {15'd0, host_ack}, 16'd1);
        chk("bb_dat3", host_dat_i, 16'h3131);
        host_req = 1'b0;
        step;
        chk("prot_never_we", {15'd0, bad_we}, 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 Parameter PROT_BASE, default 16'h7000: first word address the host port may not write.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu  if_dbus.slave  -  core data bus: adr[15:0], re, we, dat_o[15:0] in; dat_i[15:0] out.
REQ-005 mem  if_dbus.master  -  single-port data RAM with one-cycle registered read: adr, re, we, dat_o out; dat_i in.
REQ-006 host_req  input  1  host access request, held until host_ack.
REQ-007 host_we  input  1  1 = write, 0 = read; stable while host_req is high.
REQ-008 host_adr  input  16  host word address.
REQ-009 host_dat_o  input  16  host write data.
REQ-010 host_ack  output  1  one-cycle pulse completing a host access.
REQ-011 host_dat_i  output  16  host read data, valid only with host_ack on reads.
REQ-012 host_err  output  1  pulses with host_ack when a write was rejected.

Function
REQ-013 The core SHALL have absolute priority: any cycle with cpu.re or cpu.we drives mem.adr/re/we/dat_o combinationally from cpu, with zero added latency.
REQ-014 The arbiter SHALL never stall the core; the core keeps its fixed one-cycle read timing.
REQ-015 FSM states: IDLE, HOST_WAIT.
REQ-016 IDLE -> HOST_WAIT when host_req=1 and cpu.re=0 and cpu.we=0; in that cycle mem is driven from host_adr/host_we/host_dat_o with mem.re = ~host_we.
REQ-017 IDLE with host_req=1 and a core access in the same cycle: the core is served; the host stays pending and the state stays IDLE.
REQ-018 HOST_WAIT -> IDLE unconditionally after one cycle; in that cycle host_ack=1 and host_dat_i=mem.dat_i.
REQ-019 The host port SHALL NOT be granted in HOST_WAIT, giving at most one host access per two cycles; a core access in HOST_WAIT is served normally.
REQ-020 A registered owner flag (OWN_NONE, OWN_CPU, OWN_HOST) SHALL record the previous cycle's mem user; cpu.dat_i = mem.dat_i when the owner is OWN_CPU, else 16'h0.
REQ-021 A host write with host_adr >= PROT_BASE (unsigned 16-bit compare) SHALL drive mem.we=0 and mem.re=0, still enter HOST_WAIT, and pulse host_err together with host_ack.
REQ-022 Host reads SHALL never be protected.
REQ-023 Unused mem outputs SHALL be 0 in idle cycles: adr=0, re=0, we=0, dat_o=0.
REQ-024 Because the core issues at most one access every two cycles, a pending host request SHALL be granted within 2 cycles of assertion.

Reset
REQ-025 While reset=1: state=IDLE, owner=OWN_NONE, host_ack=0, host_err=0, host_dat_i=0, mem.re=0, mem.we=0.
REQ-026 Reset asserted in HOST_WAIT SHALL abort the host access with no ack; the host must re-request.
REQ-027 The first grant is possible in the cycle after reset deasserts.

Structure
REQ-028 The state enum (arb_state_t) and the owner enum (owner_t) SHALL live in package types.
REQ-029 The block is a single module with no sub-modules; the protection compare stays inline.

Verification
REQ-030 Core read only: cpu.re=1, adr=16'h0010, RAM[0x10]=16'hBEEF -> mem.re the same cycle; cpu.dat_i=16'hBEEF next cycle; host_ack stays 0.
REQ-031 Collision: host_req read of 16'h0020 and cpu.we in the same cycle -> core written first; host granted the next cycle; host_ack two cycles after the request with host_dat_i=RAM[0x20].
REQ-032 Protected write: host write of 16'h1234 to 16'h7000 -> mem.we is never asserted; host_ack=host_err=1 one cycle after grant; RAM unchanged. The same write to 16'h6FFF succeeds with host_err=0.
REQ-033 Interleave: core reads every two cycles while host_req is held continuously -> host acks every two cycles; the core never sees host data on cpu.dat_i.
REQ-034 Reset in HOST_WAIT: grant a host read, assert reset the next cycle -> no host_ack; state=IDLE; host_dat_i=0.
REQ-035 Back-to-back host: host_req held for two reads of 0x30 and 0x31 with the core idle -> grants in cycles 0 and 2; acks in cycles 1 and 3 with the correct data.
